pipe_skid_reg: RTL

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg_if.sv | 27 ++
 rtl/pipe_skid_reg.sv | 88 ++++++++
 2 files changed

// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle between a pipeline stage and its two-entry skid register.
// "slave" is the skid register; "master" is the surrounding stage logic.
interface pipe_skid_reg_if #(
    parameter int PAYLOAD_W = 70,
    parameter int CNT_W     = 16
);
    logic                 flush;
    logic                 freeze;
    logic                 in_valid;
    logic [PAYLOAD_W-1:0] in_data;
    logic                 in_ready;
    logic                 out_valid;
    logic [PAYLOAD_W-1:0] out_data;
    logic                 out_ready;
    logic [1:0]           occupancy;
    logic [CNT_W-1:0]     stall_cnt;

    modport slave (
        input  flush, freeze, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy, stall_cnt
    );

    modport master (
        output flush, freeze, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy, stall_cnt
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer between pipeline stages: main drives out_data, skid absorbs
// one extra entry so in_ready never depends combinationally on out_ready.
module pipe_skid_reg #(
    parameter int PAYLOAD_W = 70,
    parameter int CNT_W     = 16
) (
    input  logic           clk,
    input  logic           rst,
    pipe_skid_reg_if.slave bus
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t               state, state_nxt;
    logic [PAYLOAD_W-1:0] main_q, skid_q;
    logic [CNT_W-1:0]     stall_q;
    logic                 in_ready, out_valid, in_fire, out_fire;
    logic                 ld_main, ld_skid, main_from_skid;

    // rst gates in_ready so nothing is offered as accepted while reset is held
    assign in_ready  = ~rst & (state != TWO) & ~bus.freeze & ~bus.flush;
    assign out_valid = (state != EMPTY);
    assign in_fire   = bus.in_valid & in_ready;
    assign out_fire  = out_valid & bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            state <= EMPTY;
        else if (bus.flush) state <= EMPTY;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (in_fire) state_nxt = ONE;
            ONE: begin
                if (in_fire && !out_fire)      state_nxt = TWO;
                else if (!in_fire && out_fire) state_nxt = EMPTY;
            end
            TWO:     if (out_fire) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        ld_main        = 1'b0;
        ld_skid        = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: ld_main = in_fire;
            ONE: begin
                ld_main = in_fire & out_fire;
                ld_skid = in_fire & ~out_fire;
            end
            TWO: begin
                ld_main        = out_fire;
                main_from_skid = out_fire;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (bus.flush) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (ld_main) main_q <= main_from_skid ? skid_q : bus.in_data;
            if (ld_skid) skid_q <= bus.in_data;
        end
    end

    // Counts upstream-blocked cycles for performance monitoring; survives flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_q <= '0;
        else if (bus.in_valid && !in_ready && stall_q != {CNT_W{1'b1}})
            stall_q <= stall_q + 1'b1;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = main_q;
    assign bus.occupancy = state;
    assign bus.stall_cnt = stall_q;
endmodule
